// File: rtl/decode_stage.sv
// RV32I decode/issue stage: register file read with writeback bypass, busy-bit
// scoreboard for RAW stalls, and a single registered slot toward execute.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [6:0]      alu_op,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    function automatic logic [NREGS-1:0] onehot(input logic [4:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic             out_valid_r;
    logic [XLEN-1:0]  operand1_r;
    logic [XLEN-1:0]  operand2_r;
    logic [6:0]       alu_op_r;
    logic [4:0]       rd_r;
    logic             rd_we_r;
    logic             illegal_r;

    logic [4:0]       rs1_s;
    logic [4:0]       rs2_s;
    logic [4:0]       rd_s;
    logic [2:0]       funct3_s;
    logic [XLEN-1:0]  rs1_val_s;
    logic [XLEN-1:0]  rs2_val_s;
    logic [XLEN-1:0]  dec_op1_s;
    logic [XLEN-1:0]  dec_op2_s;
    logic [6:0]       dec_alu_s;
    logic             dec_illegal_s;
    logic             dec_rd_we_s;
    logic             use_rs1_s;
    logic             use_rs2_s;
    logic [NREGS-1:0] clr_s;
    logic [NREGS-1:0] set_s;
    logic [NREGS-1:0] busy_eff_s;
    logic [NREGS-1:0] busy_nxt_s;
    logic             hazard_s;
    logic             accept_s;

    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];
    assign rd_s     = instr[11:7];
    assign funct3_s = instr[14:12];

    // Register reads with x0 forced to zero and same-cycle writeback forwarded
    always_comb begin
        if (rs1_s == 5'd0) begin
            rs1_val_s = '0;
        end else if (wb_en && (wb_rd == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = regs_r[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rs2_val_s = '0;
        end else if (wb_en && (wb_rd == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = regs_r[rs2_s];
        end
    end

    // Opcode decode into the execute bundle and source-usage flags
    always_comb begin
        dec_op1_s     = '0;
        dec_op2_s     = '0;
        dec_alu_s     = 7'h70;
        dec_illegal_s = 1'b1;
        use_rs1_s     = 1'b0;
        use_rs2_s     = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                dec_alu_s     = {3'b000, instr[30], funct3_s};
                dec_op1_s     = rs1_val_s;
                dec_op2_s     = rs2_val_s;
                dec_illegal_s = 1'b0;
                use_rs1_s     = 1'b1;
                use_rs2_s     = 1'b1;
            end
            OPC_IMM: begin
                dec_alu_s     = {3'b001, (funct3_s == 3'b101) ? instr[30] : 1'b0, funct3_s};
                dec_op1_s     = rs1_val_s;
                dec_op2_s     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                dec_illegal_s = 1'b0;
                use_rs1_s     = 1'b1;
            end
            OPC_LUI: begin
                dec_alu_s     = 7'h20;
                dec_op2_s     = {instr[31:12], 12'h000};
                dec_illegal_s = 1'b0;
            end
            OPC_AUIPC: begin
                dec_alu_s     = 7'h30;
                dec_op1_s     = pc;
                dec_op2_s     = {instr[31:12], 12'h000};
                dec_illegal_s = 1'b0;
            end
            default: begin
                dec_alu_s     = 7'h70;
                dec_illegal_s = 1'b1;
            end
        endcase
        dec_rd_we_s = !dec_illegal_s && (rd_s != 5'd0);
    end

    // Hazard ignores busy bits retiring this cycle since the bypass covers them
    always_comb begin
        clr_s      = wb_en ? onehot(wb_rd) : '0;
        busy_eff_s = busy_r & ~clr_s;
        hazard_s   = in_valid && ((use_rs1_s && busy_eff_s[rs1_s]) ||
                                  (use_rs2_s && busy_eff_s[rs2_s]));
        in_ready   = (!out_valid_r || out_ready) && !hazard_s;
        accept_s   = in_valid && in_ready;
        set_s      = (accept_s && dec_rd_we_s) ? onehot(rd_s) : '0;
        busy_nxt_s = (busy_eff_s | set_s) & ~onehot(5'd0);
    end

    // Register file write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    // Busy scoreboard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Output slot: load on acceptance, empty once taken without a refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            operand1_r  <= '0;
            operand2_r  <= '0;
            alu_op_r    <= 7'h00;
            rd_r        <= 5'd0;
            rd_we_r     <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            operand1_r  <= dec_op1_s;
            operand2_r  <= dec_op2_s;
            alu_op_r    <= dec_alu_s;
            rd_r        <= rd_s;
            rd_we_r     <= dec_rd_we_s;
            illegal_r   <= dec_illegal_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign operand1  = operand1_r;
    assign operand2  = operand2_r;
    assign alu_op    = alu_op_r;
    assign rd        = rd_r;
    assign rd_we     = rd_we_r;
    assign illegal   = illegal_r;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode/issue stage: the producer side of the execute interface.
- Accepts one instruction plus PC per handshake and reads the internal 32x32 register file.
- Generates the operand1/operand2/alu_op bundle the execute stage consumes, plus rd/rd_we for writeback.
- Tracks in-flight destination registers in a busy scoreboard and stalls on RAW hazards until the writeback port retires them.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, architectural register count; x0 is hardwired to zero.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  instruction presented
- in_ready  output  1  stage accepts instruction this cycle
- instr  input  32  RV32I instruction word
- pc  input  32  PC of instr
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute stage accepts bundle
- operand1  output  32  first ALU operand
- operand2  output  32  second ALU operand
- alu_op  output  7  {class[2:0], alt, funct3[2:0]}
- rd  output  5  destination register
- rd_we  output  1  result is written back
- illegal  output  1  unsupported opcode
- wb_en  input  1  writeback strobe
- wb_rd  input  5  writeback register
- wb_data  input  32  writeback value

Behaviour:
- **Reset (rst=0, async):**
  - out_valid, operand1, operand2, alu_op, rd, rd_we and illegal are all 0.
  - All register file entries are 0 and all busy bits are 0.
  - Asserting reset mid-stall drops the held bundle; no residual busy bits remain.
- **Handshake and latency:**
  - Transfers occur when valid&&ready.
  - Output is a single registered slot; latency from input acceptance to out_valid is 1 cycle.
  - in_ready = (!out_valid || out_ready) && !hazard. The path is combinational from out_ready and the wb_* inputs.
  - Held outputs stay stable while out_valid && !out_ready.
  - out_valid falls after the bundle is taken when no new input is accepted that cycle.
- **Decode, by opcode:**
  - OP (0110011): class=000, alt=instr[30], op1=rs1, op2=rs2.
  - OP-IMM (0010011): class=001; alt=instr[30] only when funct3=101, else 0; op1=rs1; op2=sign-extended instr[31:20].
  - LUI (0110111): class=010, alt=0, funct3=000, op1=0, op2={instr[31:12],12'b0}.
  - AUIPC (0010111): class=011, alt=0, funct3=000, op1=pc, op2={instr[31:12],12'b0}.
  - Any other opcode: alu_op=7'h70, operands 0, rd_we=0, illegal=1.
  - rd=instr[11:7]. rd_we=1 for legal instructions with rd!=0.
- **Register file:**
  - Reads of x0 return 0.
  - wb_en with wb_rd=0 is ignored.
  - Write-through bypass: if wb_en and wb_rd matches rs1/rs2 in the same cycle, the read returns wb_data.
- **Scoreboard and hazard:**
  - hazard = in_valid && (rs1 used && busy[rs1] || rs2 used && busy[rs2]).
  - rs1 is used by OP and OP-IMM; rs2 is used by OP only.
  - A busy bit cleared by wb_en in the same cycle does not cause a hazard (bypass applies).
  - On acceptance with rd_we=1, busy[rd] is set.
  - On wb_en, busy[wb_rd] is cleared.
  - If set and clear hit the same register in one cycle, set wins.
  - busy[0] is never set.
- **Stalls and illegal input:**
  - While stalled, instr/pc must be held by the producer.
  - Nothing is latched until acceptance.
  - An illegal instruction still passes through the handshake with illegal=1 and no busy update.

Test Plan:
- **Reset values:** reset, release, present nothing -> all outputs 0, in_ready=1, out_valid=0.
- **ADDI with backpressure:** ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, operand1=0, operand2=5, alu_op=0x10, rd=1, rd_we=1; busy[1]=1.
  - Repeat with out_ready=0 for 3 cycles -> bundle held stable and in_ready=0 while full.
- **RAW stall and bypass:** after ADDI x1, present ADD x3,x1,x2 (0x002081B3) -> in_ready=0 until wb_en=1, wb_rd=1, wb_data=5.
  - In the wb cycle, in_ready=1; next cycle operand1=5, operand2=0, alu_op=0x00, rd=3.
- **Shift and upper-immediate decode:**
  - x1=0xFFFFFFF0 written via wb; SRAI x2,x1,3 (0x4030D113) -> operand1=0xFFFFFFF0, operand2=0x403, alu_op=0x1D.
  - LUI x5,0x12345 (0x123452B7) -> operand1=0, operand2=0x12345000, alu_op=0x20.
- **Illegal and x0 handling:**
  - instr=0x00000000 -> illegal=1, alu_op=0x70, rd_we=0, no busy bit set.
  - ADDI x0,x0,1 -> rd_we=0.
  - wb_en with wb_rd=0, wb_data=7, then ADD x3,x0,x0 -> operands 0.
- **Reset mid-operation:** stall ADD behind busy[1], assert rst for 1 cycle -> out_valid=0, busy clear; the re-presented ADD is accepted at once with operand1=0.
